// File: rtl/truth_table_sweeper_if.sv
// Control/result bus of truth_table_sweeper: start request, expected table, and sweep results.
// start is a request that is accepted only on a clock edge where the sweeper is idle
// (busy=0 and done=0); while busy or done is high the request is ignored, not queued.
interface truth_table_sweeper_if;
  logic        start;
  logic [15:0] expected;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  mismatch_count;
  logic [3:0]  first_fail;
  logic [15:0] captured;

  modport master (
    output start, expected,
    input  busy, done, pass, mismatch_count, first_fail, captured
  );

  modport slave (
    input  start, expected,
    output busy, done, pass, mismatch_count, first_fail, captured
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Sweeps a 4-input boolean block through all 16 vectors and checks each result against a table.
// Optional build macro STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module truth_table_sweeper #(
  parameter int unsigned SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  truth_table_sweeper_if.slave bus,
  input  logic                 s,
  output logic                 x,
  output logic                 y,
  output logic                 w,
  output logic                 z,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] exp_q, exp_d;
  logic [15:0] cap_q, cap_d;
  logic [4:0]  mis_q, mis_d;
  logic [3:0]  ff_q, ff_d;
  logic        pass_q, pass_d;
  logic        mism;
  logic        last_vec;

  assign mism = s ^ exp_q[idx_q];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    cap_d    = cap_q;
    mis_d    = mis_q;
    ff_d     = ff_q;
    pass_d   = pass_q;
    last_vec = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          exp_d   = bus.expected;
          cap_d   = 16'h0000;
          mis_d   = 5'd0;
          ff_d    = 4'd0;
          pass_d  = 1'b0;
          idx_d   = 4'd0;
          cnt_d   = 4'd0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = 4'd0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_SAMPLE: begin
        cap_d[idx_q] = s;
        if (mism) begin
          mis_d = mis_q + 5'd1;
          if (mis_q == 5'd0) ff_d = idx_q;
        end
        last_vec = (idx_q == 4'd15);
`ifdef STOP_ON_FAIL_EN
        last_vec = last_vec | mism;
`endif
        if (last_vec) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        // pass only becomes visible once the sweep has fully retired
        pass_d  = (mis_q == 5'd0);
        idx_d   = 4'd0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 4'd0;
      exp_q   <= 16'h0000;
      cap_q   <= 16'h0000;
      mis_q   <= 5'd0;
      ff_q    <= 4'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      cap_q   <= cap_d;
      mis_q   <= mis_d;
      ff_q    <= ff_d;
      pass_q  <= pass_d;
    end
  end

  assign {x, y, w, z}       = idx_q;
  assign bus.busy           = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign bus.done           = (state_q == ST_DONE);
  assign bus.pass           = pass_q;
  assign bus.mismatch_count = mis_q;
  assign bus.first_fail     = ff_q;
  assign bus.captured       = cap_q;
  assign dbg_state          = state_q;

endmodule
